// File: rtl/framed_deserializer.sv
// Start-bit framed serial receiver: after a start bit, WORDS_PER_FRAME back-to-back words are assembled
// into a one-entry valid/ready register (valid on the last-bit edge); an unconsumed word is overwritten with an overflow pulse.
module framed_deserializer #(
    parameter int   WORD_SIZE       = 8,
    parameter int   WORDS_PER_FRAME = 2,
    parameter logic START_BIT       = 1'b0,
    parameter bit   LSB_FIRST       = 1'b1,
    parameter bit   STOP_BIT_EN     = 1'b1,
    parameter logic STOP_BIT        = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               data_in,
    input  logic                               word_ready,
    output logic [WORD_SIZE-1:0]               word_out,
    output logic                               word_valid,
    output logic [$clog2(WORDS_PER_FRAME):0]   word_index,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               stop_error,
    output logic                               overflow
);

    localparam int BW = $clog2(WORD_SIZE);
    localparam int IW = $clog2(WORDS_PER_FRAME) + 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_SIZE - 1);
    localparam logic [IW-1:0] LAST_WORD = IW'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [WORD_SIZE-1:0]   shift_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [IW-1:0]          word_cnt_q;
    logic [WORD_SIZE-1:0]   word_out_q;
    logic                   word_valid_q;
    logic [IW-1:0]          word_index_q;
    logic                   frame_done_q;
    logic                   stop_error_q;
    logic                   overflow_q;
    logic [WORD_SIZE-1:0]   shift_d;

    // Word as it stands once the bit currently on the line is included.
    always_comb begin
        if (LSB_FIRST) begin
            shift_d = {data_in, shift_q[WORD_SIZE-1:1]};
        end else begin
            shift_d = {shift_q[WORD_SIZE-2:0], data_in};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_index_q <= '0;
            frame_done_q <= 1'b0;
            stop_error_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            stop_error_q <= 1'b0;
            overflow_q   <= 1'b0;
            if (word_valid_q && word_ready) begin
                word_valid_q <= 1'b0;
            end

            if (abort && state_q != IDLE) begin
                state_q    <= IDLE;
                shift_q    <= '0;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            state_q    <= HUNT;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                        end
                    end
                    HUNT: begin
                        if (data_in == START_BIT) begin
                            state_q   <= SHIFT;
                            bit_cnt_q <= '0;
                        end
                    end
                    SHIFT: begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            word_out_q   <= shift_d;
                            word_valid_q <= 1'b1;
                            word_index_q <= word_cnt_q;
                            overflow_q   <= word_valid_q && !word_ready;
                            bit_cnt_q    <= '0;
                            word_cnt_q   <= word_cnt_q + IW'(1);
                            if (word_cnt_q == LAST_WORD) begin
                                if (STOP_BIT_EN) begin
                                    state_q <= STOP;
                                end else begin
                                    state_q      <= IDLE;
                                    frame_done_q <= 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                    STOP: begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                        stop_error_q <= (data_in != STOP_BIT);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_index = word_index_q;
    assign frame_done = frame_done_q;
    assign stop_error = stop_error_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE) || start;

endmodule

// File: tb/tb_framed_deserializer.sv
// Bench for framed_deserializer: directed vector table, hand-written corner sequences and randomized frames vs a frame-level model.
module tb_framed_deserializer;

    logic clock, reset_n, start, start2, abort, data_in, word_ready;
    logic [7:0] w_out, w2_out;
    logic [1:0] w_idx;
    logic [0:0] w2_idx;
    logic w_vld, busy, done, serr, ovf;
    logic w2_vld, busy2, done2, serr2, ovf2;

    int nerr = 0;
    int nchk = 0;

    framed_deserializer u1 (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .data_in(data_in),
        .word_ready(word_ready), .word_out(w_out), .word_valid(w_vld), .word_index(w_idx),
        .busy(busy), .frame_done(done), .stop_error(serr), .overflow(ovf)
    );

    framed_deserializer #(.WORD_SIZE(8), .WORDS_PER_FRAME(1), .LSB_FIRST(1'b0), .STOP_BIT_EN(1'b0)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .abort(abort), .data_in(data_in),
        .word_ready(word_ready), .word_out(w2_out), .word_valid(w2_vld), .word_index(w2_idx),
        .busy(busy2), .frame_done(done2), .stop_error(serr2), .overflow(ovf2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic st; logic d;
        logic v; logic [7:0] out; logic [1:0] idx; logic dn; logic bsy;
    } vec_t;

    typedef struct {
        logic st; logic d; int ev; logic [7:0] w; logic [1:0] idx; logic stp;
    } rcyc_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic st, input logic ab, input logic d, input logic rdy);
        start = st; abort = ab; data_in = d; word_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input logic rdy);
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, w[k], rdy);
    endtask

    function automatic vec_t mk(logic st, logic d, logic v, logic [7:0] o, logic [1:0] i, logic dn, logic b);
        vec_t r;
        r.st = st; r.d = d; r.v = v; r.out = o; r.idx = i; r.dn = dn; r.bsy = b;
        return r;
    endfunction

    vec_t tbl[20];
    rcyc_t rq[$];
    logic [7:0] a5, c3, c1;
    int ovf_cnt;
    logic pending;
    logic [7:0] eout;
    logic [1:0] eidx;
    logic eovf;

    initial begin
        start = 0; start2 = 0; abort = 0; data_in = 1; word_ready = 1; reset_n = 0;
        a5 = 8'hA5; c3 = 8'h3C; c1 = 8'hC1;

        // Reset state
        @(posedge clock); #1;
        chk("rst_vld", w_vld, 0); chk("rst_out", w_out, 0); chk("rst_idx", w_idx, 0);
        chk("rst_done", done, 0); chk("rst_serr", serr, 0); chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0); chk("rst_vld2", w2_vld, 0);
        @(posedge clock); #1;
        reset_n = 1;

        // Test 1 as a vector table: 0xA5 then 0x3C, good stop bit, ready high
        tbl[0] = mk(1, 1, 0, 8'h00, 0, 0, 1);
        tbl[1] = mk(0, 0, 0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 7; k++) tbl[2+k] = mk(0, a5[k], 0, 8'h00, 0, 0, 1);
        tbl[9] = mk(0, a5[7], 1, 8'hA5, 0, 0, 1);
        for (int k = 0; k < 7; k++) tbl[10+k] = mk(0, c3[k], 0, 8'hA5, 0, 0, 1);
        tbl[17] = mk(0, c3[7], 1, 8'h3C, 1, 0, 1);
        tbl[18] = mk(0, 1, 0, 8'h3C, 1, 1, 0);
        tbl[19] = mk(0, 1, 0, 8'h3C, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].st, 1'b0, tbl[i].d, 1'b1);
            chk($sformatf("t1_vld[%0d]", i), w_vld, tbl[i].v);
            chk($sformatf("t1_out[%0d]", i), w_out, tbl[i].out);
            chk($sformatf("t1_idx[%0d]", i), w_idx, tbl[i].idx);
            chk($sformatf("t1_done[%0d]", i), done, tbl[i].dn);
            chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].bsy);
            chk($sformatf("t1_serr[%0d]", i), serr, 0);
            chk($sformatf("t1_ovf[%0d]", i), ovf, 0);
        end

        // Test 2: bad stop bit
        cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
        send_bits(8'hA5, 1);
        chk("t2_vld0", w_vld, 1); chk("t2_out0", w_out, 8'hA5);
        send_bits(8'h3C, 1);
        chk("t2_vld1", w_vld, 1); chk("t2_out1", w_out, 8'h3C); chk("t2_idx1", w_idx, 1);
        cyc(0, 0, 0, 1);
        chk("t2_done", done, 1); chk("t2_serr", serr, 1); chk("t2_keep", w_out, 8'h3C);
        cyc(0, 0, 1, 1);
        chk("t2_done_clr", done, 0); chk("t2_serr_clr", serr, 0); chk("t2_busy", busy, 0);

        // Test 3: consumer stalled for the whole frame
        ovf_cnt = 0;
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin cyc(0, 0, a5[k], 0); ovf_cnt += int'(ovf); end
        chk("t3_vld0", w_vld, 1); chk("t3_ovf0", ovf, 0);
        for (int k = 0; k < 8; k++) begin cyc(0, 0, c3[k], 0); ovf_cnt += int'(ovf); end
        chk("t3_ovf1", ovf, 1); chk("t3_out", w_out, 8'h3C); chk("t3_idx", w_idx, 1);
        cyc(0, 0, 1, 0); ovf_cnt += int'(ovf);
        chk("t3_done", done, 1); chk("t3_vld_hold", w_vld, 1);
        cyc(0, 0, 1, 0); ovf_cnt += int'(ovf);
        chk("t3_vld_hold2", w_vld, 1); chk("t3_ovf_once", ovf_cnt, 1);
        cyc(0, 0, 1, 1);
        chk("t3_vld_clr", w_vld, 0); chk("t3_out_hold", w_out, 8'h3C);

        // Test 4: MSB-first single word, no stop bit
        start2 = 1; cyc(0, 0, 1, 1); start2 = 0;
        chk("t4_busy", busy2, 1);
        cyc(0, 0, 0, 1);
        for (int k = 7; k >= 0; k--) cyc(0, 0, c1[k], 1);
        chk("t4_vld", w2_vld, 1); chk("t4_out", w2_out, 8'hC1); chk("t4_idx", w2_idx, 0);
        chk("t4_done", done2, 1); chk("t4_idle", busy2, 0); chk("t4_serr", serr2, 0);
        cyc(0, 0, 1, 1);
        chk("t4_done_clr", done2, 0); chk("t4_vld_clr", w2_vld, 0);

        // Test 5: abort mid-word, abort on completion edge, abort beats start
        cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 1);
        chk("t5_busy", busy, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, k[0], 1);
            chk("t5_novld", w_vld, 0); chk("t5_nodone", done, 0);
        end
        cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 1);
        chk("t5_ab_cmpl_vld", w_vld, 0); chk("t5_ab_cmpl_out", w_out, 8'h3C); chk("t5_ab_busy", busy, 0);
        cyc(1, 1, 1, 1);
        cyc(0, 0, 0, 1);
        chk("t5_ab_over_start", busy, 0);
        cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
        send_bits(8'h5A, 1);
        chk("t5_w0", w_out, 8'h5A); chk("t5_i0", w_idx, 0); chk("t5_v0", w_vld, 1);
        send_bits(8'h81, 1);
        chk("t5_w1", w_out, 8'h81); chk("t5_i1", w_idx, 1);
        cyc(0, 0, 1, 1);
        chk("t5_done", done, 1); chk("t5_serr", serr, 0);

        // Test 6: asynchronous reset mid-frame
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        send_bits(8'h77, 0);
        chk("t6_pre_vld", w_vld, 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
        #2 reset_n = 0;
        #1;
        chk("t6_vld", w_vld, 0); chk("t6_out", w_out, 0); chk("t6_idx", w_idx, 0);
        chk("t6_done", done, 0); chk("t6_ovf", ovf, 0); chk("t6_busy", busy, 0);
        @(posedge clock); #1;
        reset_n = 1;
        cyc(1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 1);
            chk("t6_hunt_busy", busy, 1); chk("t6_hunt_vld", w_vld, 0);
        end
        cyc(0, 1, 1, 1);
        chk("t6_abort_idle", busy, 0);

        // Randomized frames against a frame-level model
        pending = 0; eout = 8'h00; eidx = 2'd0;
        for (int f = 0; f < 40; f++) begin
            logic [15:0] bits;
            logic stp;
            rcyc_t c;
            bits = 16'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            rq.delete();
            c = '{st: 0, d: 1, ev: 0, w: 0, idx: 0, stp: 0};
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                c.d = 1'($urandom); rq.push_back(c);
            end
            c.st = 1; c.d = 1'($urandom); rq.push_back(c);
            c.st = 0; c.d = 1;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) rq.push_back(c);
            c.d = 0; rq.push_back(c);
            for (int k = 0; k < 16; k++) begin
                c.d = bits[k];
                c.ev = (k % 8 == 7) ? 1 : 0;
                c.w = (k < 8) ? bits[7:0] : bits[15:8];
                c.idx = 2'(k / 8);
                rq.push_back(c);
            end
            c.d = stp; c.ev = 2; c.stp = stp; rq.push_back(c);

            foreach (rq[i]) begin
                logic rdy;
                rdy = 1'($urandom);
                cyc(rq[i].st, 1'b0, rq[i].d, rdy);
                if (rq[i].ev == 1) begin
                    eovf = pending && !rdy;
                    pending = 1; eout = rq[i].w; eidx = rq[i].idx;
                end else begin
                    eovf = 0;
                    if (pending && rdy) pending = 0;
                end
                chk("rnd_vld", w_vld, pending);
                chk("rnd_out", w_out, eout);
                chk("rnd_idx", w_idx, eidx);
                chk("rnd_ovf", ovf, eovf);
                chk("rnd_done", done, rq[i].ev == 2);
                chk("rnd_serr", serr, (rq[i].ev == 2) && !rq[i].stp);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
